// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then an
// arithmetic right shift of {acc, q, q_1} by one bit.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Shift the sign of the widened accumulator back into its top bit.
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Free-running sequential Booth multiplier: LOAD, WIDTH x STEP, DONE, repeat.
// out carries the last completed signed product and changes only in DONE.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_nx),
    .q_next   (q_nx),
    .q_1_next (q_1_nx)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:    state_next = STEP;
      STEP:    if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      count <= '0;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        LOAD: begin
          // Sign-extend M so -2^(WIDTH-1) can be negated without overflow.
          m     <= {a[WIDTH-1], a};
          q     <= b;
          acc   <= '0;
          q_1   <= 1'b0;
          count <= CW'(WIDTH);
        end
        STEP: begin
          acc   <= acc_nx;
          q     <= q_nx;
          q_1   <= q_1_nx;
          count <= count - 1'b1;
        end
        DONE: out <= {acc[WIDTH-1:0], q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Randomized + directed bench; expected products come from integer
// multiplication of the operands seen at each LOAD edge.
module tb_booth_multiplier;
  localparam int W = 4;
  localparam int P = W + 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] out;

  int checks = 0;
  int passed = 0;

  int             cyc = 0;
  logic [W-1:0]   cap_a = '0, cap_b = '0;
  logic [2*W-1:0] exp_out = '0;

  always #5 clk = ~clk;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .out   (out)
  );

  function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return (2*W)'(xi * yi);
  endfunction

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // One clock edge; the model tracks cycle position from the last reset.
  task automatic tick(input string tag);
    logic         r;
    logic [W-1:0] sa, sb;
    r  = reset;
    sa = a;
    sb = b;
    @(posedge clk);
    #1;
    if (r) begin
      cyc     = 0;
      exp_out = '0;
    end else begin
      cyc++;
      if ((cyc - 1) % P == 0) begin
        cap_a = sa;
        cap_b = sb;
      end
      if (cyc % P == 0) exp_out = mul_ref(cap_a, cap_b);
    end
    chk(tag, out, exp_out);
  endtask

  // One full computation window; optionally disturb operands mid-STEP.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit chg, input logic [W-1:0] nx, input logic [W-1:0] ny,
                        input bit lit_en, input logic [2*W-1:0] lit);
    a = x;
    b = y;
    for (int i = 0; i < P; i++) begin
      if (chg && i == 2) begin
        a = nx;
        b = ny;
      end
      tick(tag);
    end
    if (lit_en) chk({tag, "_lit"}, out, lit);
  endtask

  initial begin
    reset = 1'b1;
    a = 4'd6;
    b = 4'd4;
    tick("reset");
    chk("reset_lit", out, 8'h00);
    reset = 1'b0;

    run_op("basic",     4'd6,  4'd4,  0, 4'd0, 4'd0, 1, 8'h18);
    run_op("recompute", 4'd6,  4'd4,  0, 4'd0, 4'd0, 1, 8'h18);
    run_op("neg8x7",    4'h8,  4'd7,  0, 4'd0, 4'd0, 1, 8'hC8);
    run_op("7xneg1",    4'd7,  4'hF,  0, 4'd0, 4'd0, 1, 8'hF9);
    run_op("neg8xneg8", 4'h8,  4'h8,  0, 4'd0, 4'd0, 1, 8'h40);
    run_op("0xneg5",    4'd0,  4'hB,  0, 4'd0, 4'd0, 1, 8'h00);
    run_op("chg_a",     4'd6,  4'd4,  1, 4'd3, 4'd4, 1, 8'h18);
    run_op("chg_next",  4'd3,  4'd4,  0, 4'd0, 4'd0, 1, 8'h0C);

    // Abort a computation part way through STEP.
    a = 4'd5;
    b = 4'd3;
    tick("pre_rst");
    tick("pre_rst");
    tick("pre_rst");
    reset = 1'b1;
    tick("rst_mid");
    chk("rst_mid_lit", out, 8'h00);
    reset = 1'b0;
    run_op("post_rst",  4'd5,  4'd3,  0, 4'd0, 4'd0, 1, 8'h0F);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", W'($urandom), W'($urandom), bit'($urandom_range(0, 1)),
             W'($urandom), W'($urandom), 0, '0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
